alu_seq: RTL

Parametrised multi-cycle successor to the MIPS datapath ALU. Single-cycle operations complete with a registered one-cycle latency. MUL and optional DIV run as iterative shift-add / restoring-divide engines under a Start/Busy/Done handshake. Sits in the EX stage; the pipeline controller stalls while Busy is high and consumes ALUResult/Hi on Done.

---
 rtl/alu_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: registered single-cycle ops, iterative MUL, optional DIV (ALU_DIV_EN)
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_JUMP = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SLL  = 4'd10;
  localparam logic [3:0] OP_SGT  = 4'd11;
  localparam logic [3:0] OP_CLZ  = 4'd12;
  localparam logic [3:0] OP_ROTR = 4'd13;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd14;
`endif

  // iteration counter wraps back to 0 after the last step, ready for the next launch
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t               state;
  state_t               state_next;
  logic [SHW-1:0]       iter;
  logic [2*WIDTH-1:0]   acc;        // MUL: {partial high, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opnd;       // multiplicand or divisor, latched at launch
  logic                 start_mul;
  logic                 start_div;
  logic [WIDTH-1:0]     single_res;
  logic [SHW-1:0]       sll_amt;
  logic [SHW-1:0]       rot_amt;
  logic [SHW:0]         lead_cnt;
  logic                 lead_run;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  assign start_mul = (ALUControl == OP_MUL);
`ifdef ALU_DIV_EN
  assign start_div = (ALUControl == OP_DIV);
`else
  assign start_div = 1'b0;
`endif
  assign Busy    = (state != S_IDLE);
  assign sll_amt = SHW'(B >> 6);
  assign rot_amt = B[SHW-1:0];

  // shift-add step: add multiplicand into the high half when the multiplier LSB is set, then shift right
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

`ifdef ALU_DIV_EN
  logic               rem_msb;
  logic [WIDTH-1:0]   rem_low;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_borrow;
  logic               div_take;
  logic [2*WIDTH-1:0] div_next;

  // restoring step: shift next dividend bit into the remainder, subtract when it fits
  assign {rem_msb, rem_low}     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign {rem_borrow, rem_diff} = {1'b0, rem_low} - {1'b0, opnd};
  assign div_take               = rem_msb | ~rem_borrow;
  assign div_next = div_take ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                             : {rem_low,  acc[WIDTH-2:0], 1'b0};
`endif

  // single-cycle result, including the leading-bit counter for CLO/CLZ
  always_comb begin
    lead_cnt = '0;
    lead_run = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (lead_run && (A[i] == B[0])) lead_cnt = lead_cnt + 1'b1;
      else                            lead_run = 1'b0;
    end
    single_res = '0;
    case (ALUControl)
      OP_AND:  single_res = A & B;
      OP_OR:   single_res = A | B;
      OP_ADD:  single_res = A + B;
      OP_NOR:  single_res = ~(A | B);
      OP_SUB:  single_res = A - B;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_JUMP: single_res = '0;
      OP_SLL:  single_res = A << sll_amt;
      OP_SGT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) > $signed(B))};
      OP_CLZ:  single_res = {{(WIDTH-SHW-1){1'b0}}, lead_cnt};
      OP_ROTR: single_res = (A >> rot_amt) | (A << (WIDTH - int'(rot_amt)));
      default: single_res = '0;
    endcase
  end

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // next-state: launch from IDLE, WIDTH iterations, then one finish cycle
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (start_mul)      state_next = S_MUL;
          else if (start_div) state_next = S_DIV;
        end
      end
      S_MUL, S_DIV: if (iter == LAST_ITER) state_next = S_FIN;
      S_FIN:        state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // datapath: operand latch, iteration engine, result/Hi/Zero/Done registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ALUResult <= '0;
      Hi        <= '0;
      Zero      <= 1'b1;
      Done      <= 1'b0;
      iter      <= '0;
      acc       <= '0;
      opnd      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (start_mul) begin
              acc  <= {{WIDTH{1'b0}}, B};
              opnd <= A;
              iter <= '0;
            end else if (start_div) begin
              acc  <= {{WIDTH{1'b0}}, A};
              opnd <= B;
              iter <= '0;
            end else begin
              ALUResult <= single_res;
              Zero      <= (single_res == '0);
              Done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc  <= mul_next;
          iter <= iter + 1'b1;
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          acc  <= div_next;
          iter <= iter + 1'b1;
        end
`endif
        S_FIN: begin
          ALUResult <= acc[WIDTH-1:0];
          Hi        <= acc[2*WIDTH-1:WIDTH];
          Zero      <= (acc[WIDTH-1:0] == '0);
          Done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
